// File: rtl/shift_seq_ctrl_pkg.sv
// rtl/shift_seq_ctrl_pkg.sv - shared op/state encodings and pipeline polarity constants
package shift_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    SHOP_SLL  = 2'b00,
    SHOP_SRL  = 2'b01,
    SHOP_SRA  = 2'b10,
    SHOP_ROTR = 2'b11
  } shop_e;

  typedef enum logic [1:0] {
    SHST_IDLE  = 2'b00,
    SHST_SHIFT = 2'b01,
    SHST_DONE  = 2'b10
  } shst_e;

  // Polarities expected by the pipeline stall controller.
  localparam logic STALL_ON  = 1'b1;
  localparam logic STALL_OFF = 1'b0;
  localparam logic READY_ON  = 1'b1;
  localparam logic READY_OFF = 1'b0;

  // Width of a 0..step shift amount.
  function automatic int amt_width(input int step);
    return $clog2(step) + 1;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_shift_step.sv
// rtl/shift_seq_ctrl_shift_step.sv - combinational 0..STEP position shifter with op-dependent fill
module shift_step
  import shift_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STEP   = 4,
  parameter int AMT_W  = amt_width(STEP)
) (
  input  logic [DATA_W-1:0] acc_i,
  input  shop_e             op_i,
  input  logic              sign_i,
  input  logic [AMT_W-1:0]  amt_i,
  output logic [DATA_W-1:0] result_o
);

  localparam logic [DATA_W-1:0] ONES = '1;

  // One mux level per amount bit, each shifting by a fixed power of two.
  always_comb begin
    result_o = acc_i;
    for (int i = 0; i < AMT_W; i++) begin
      if (amt_i[i]) begin
        case (op_i)
          SHOP_SLL: result_o = result_o << (1 << i);
          SHOP_SRL: result_o = result_o >> (1 << i);
          SHOP_SRA: result_o = (result_o >> (1 << i)) |
                               (sign_i ? ~(ONES >> (1 << i)) : '0);
          default:  result_o = (result_o >> (1 << i)) |
                               (result_o << (DATA_W - (1 << i)));
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - multi-cycle stepped shift sequencer with pipeline stall request
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              annul_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [4:0]        sa_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ready_o,
  output logic              stallreq_o
);

  localparam int         AMT_W    = amt_width(STEP);
  localparam logic [4:0] STEP_REM = 5'(STEP);

  shst_e             state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [4:0]        rem_q, rem_d;
  shop_e             op_q, op_d;
  logic              sign_q, sign_d;

  logic [AMT_W-1:0]  step_amt;
  logic [DATA_W-1:0] step_acc;

  // Never shift further than the remaining count in one cycle.
  assign step_amt = (rem_q > STEP_REM) ? AMT_W'(STEP) : rem_q[AMT_W-1:0];

  shift_step #(
    .DATA_W (DATA_W),
    .STEP   (STEP),
    .AMT_W  (AMT_W)
  ) u_shift_step (
    .acc_i    (acc_q),
    .op_i     (op_q),
    .sign_i   (sign_q),
    .amt_i    (step_amt),
    .result_o (step_acc)
  );

  // Sequencer: next state, datapath updates and gated outputs; annul wins over all.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    op_d       = op_q;
    sign_d     = sign_q;
    ready_o    = READY_OFF;
    result_o   = '0;
    stallreq_o = STALL_OFF;

    if (annul_i) begin
      state_d = SHST_IDLE;
      acc_d   = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        SHST_IDLE: begin
          if (start_i) begin
            acc_d      = data_i;
            rem_d      = sa_i;
            op_d       = shop_e'(op_i);
            sign_d     = data_i[DATA_W-1];
            state_d    = (sa_i == 5'd0) ? SHST_DONE : SHST_SHIFT;
            stallreq_o = STALL_ON;
          end
        end
        SHST_SHIFT: begin
          acc_d      = step_acc;
          rem_d      = rem_q - 5'(step_amt);
          stallreq_o = STALL_ON;
          if (rem_q <= STEP_REM) begin
            state_d = SHST_DONE;
          end
        end
        SHST_DONE: begin
          ready_o  = READY_ON;
          result_o = acc_q;
          state_d  = SHST_IDLE;
        end
        default: begin
          state_d = SHST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SHST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= SHOP_SLL;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
    end
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Multi-cycle shift sequencer for the EX stage. It accepts one shift request at a time (SLL, SRL, SRA, ROTR) and performs it iteratively, STEP bit positions per cycle, on a latched copy of the operand. It holds the pipeline via `stallreq_o` to the stall controller until the result is ready. It lets EX drop the single-cycle 32-bit barrel shifter in favour of a small stepped unit, and honours flush/annul from the exception path.

## Interface
Parameters:
- `DATA_W`, 32, operand and result width.
- `STEP`, 4, maximum bit positions shifted per cycle. Must be a power of two, 1..16.

Ports:
- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst`  in  1  reset: one clock; reset is asynchronous and active-high.
- `start_i`  in  1  EX requests a shift. Sampled only in IDLE.
- `annul_i`  in  1  flush/abort. Has priority over everything except `rst`.
- `op_i`  in  2  shift op: 00 SLL, 01 SRL, 10 SRA, 11 ROTR (rotate right).
- `data_i`  in  DATA_W  operand (rt value).
- `sa_i`  in  5  shift amount, 0..31.
- `result_o`  out  DATA_W  shifted value. Valid only while `ready_o`=1, otherwise 0.
- `ready_o`  out  1  result valid. Asserted for exactly one cycle per completed request.
- `stallreq_o`  out  1  stall request to the pipeline controller.

## Operation
- States: IDLE, SHIFT, DONE. Registers: `acc` (DATA_W), `rem` (5 bits), `op_q` (2 bits), `sign_q` (1 bit).
- IDLE:
  - On `start_i`=1 and `annul_i`=0: latch `acc`←`data_i`, `rem`←`sa_i`, `op_q`←`op_i`, `sign_q`←`data_i[DATA_W-1]`.
  - Next state is DONE if `sa_i`=0, otherwise SHIFT.
- SHIFT, each edge:
  - Shift `acc` by `n` = min(`rem`, STEP) using `op_q`.
  - Fill rules: SLL fills 0s on the right; SRL fills 0s on the left; SRA fills `sign_q`; ROTR wraps LSBs to the MSBs.
  - `rem`←`rem`−`n`. When `rem`≤STEP, this is the last step and the next state is DONE.
- DONE:
  - `ready_o`=1 and `result_o`=`acc`.
  - Next state is unconditionally IDLE.
  - `start_i` during DONE is ignored; a new request is accepted in IDLE on the following cycle.
- `stallreq_o` = (IDLE & `start_i` & !`annul_i`) | SHIFT. It is combinational and deasserted in DONE, so the pipeline advances in the same cycle the result is consumed.
- `annul_i`=1 in any state:
  - Next state is IDLE and `acc`/`rem` are cleared.
  - `ready_o` is not asserted for the aborted request.
  - `stallreq_o` is forced to 0 in that cycle.
- `rst` at any point (including mid-SHIFT) sends the block to IDLE immediately and clears all registers.
- Shift counts are modulo nothing: `sa_i` is 5-bit, so at most 31, and ROTR by 0 or by a multiple of 32 returns the operand unchanged.

## Timing
- Reset values: state IDLE, `acc`=0, `rem`=0, `op_q`=0, `sign_q`=0, `result_o`=0, `ready_o`=0, `stallreq_o`=0.
- Request accepted in cycle 0. Cycles 1..k are SHIFT, where k = ceil(`sa_i`/STEP). `ready_o`=1 in cycle k+1.
- `sa_i`=0 gives `ready_o` in cycle 1.
- With STEP=4, `sa_i`=31 gives k=8 and `ready_o` in cycle 9.
- `stallreq_o` is high in cycles 0..k and low in cycle k+1.
- Back-to-back throughput is one request per k+2 cycles.
- `data_i`, `op_i` and `sa_i` changing after acceptance have no effect.

## Structure
- The shared defines header carries: the op encodings `SHOP_SLL`/`SHOP_SRL`/`SHOP_SRA`/`SHOP_ROTR`, the state encodings `SHST_IDLE`/`SHST_SHIFT`/`SHST_DONE`, and the stall/ready polarity constants already used by the pipeline controller.
- One sub-module, `shift_step`, is natural. It is purely combinational: it shifts `acc` by 0..STEP using op and sign-fill, with `$clog2(STEP)+1` mux levels.
- The FSM, the counter and the output gating stay in `shift_seq_ctrl`.

## Test plan
- Reset and idle:
  - Assert `rst` mid-SHIFT (SLL `0x00000001` by 31, after 3 cycles), then release → IDLE immediately with all outputs 0.
  - A fresh SLL `0x00000001` by 31 then gives `0x80000000` with `ready_o` in cycle 9.
- SLL/SRL: SLL `0x00000404` by 8 → `0x00040400`, `ready_o` in cycle 3. SRL `0x02020000` by 8 → `0x00020200`.
- SRA sign fill: `0x80800000` by 16 → `0xffff8080` (cycle 5). `0x80800000` by 24 → `0xffffff80` (cycle 7). `0x00001010` by 4 → `0x00000101`.
- ROTR and zero shift: ROTR `0x12345678` by 4 → `0x81234567` (cycle 2). SLL `0x04040404` by 0 → `0x04040404`, `ready_o` in cycle 1, `stallreq_o` high only in cycle 0.
- Annul: start SRL `0xffffffff` by 20, assert `annul_i` in cycle 2 → IDLE in cycle 3, no `ready_o` pulse, `stallreq_o`=0 from cycle 2. A new request in cycle 3 completes normally.
- Back-to-back: hold `start_i` high across two requests (SLL by 5, then SRA by 1) → the second is accepted only in the IDLE cycle after DONE, and exactly two `ready_o` pulses are seen.
